// File: rtl/alu_issue.sv
// alu_issue
//   Execute-stage issuer for a registered, clock-enabled ALU. Accepts one
//   RV32I OP / OP-IMM / LUI instruction with its register values, decodes it
//   into an ALU operation plus two operands, pulses the ALU clock enable for
//   one cycle and then presents the ALU's registered result on a writeback
//   handshake toward the register-file write port.
//
//   ALU operation encoding on alu_op:
//     0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSL, 6 LSR
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           instruction + operand handshake
//   in_instr, in_rs1_val,
//   in_rs2_val                    instruction word and register values
//   alu_ce, alu_op,
//   alu_operand1, alu_operand2    ALU control and operands (valid in EXEC)
//   alu_result                    registered ALU result
//   wb_valid / wb_ready           writeback handshake
//   wb_rd, wb_data, wb_we,
//   wb_illegal                    writeback payload
module alu_issue #(
  parameter int ENABLE_LUI   = 1,
  parameter int ENABLE_OPIMM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  output logic        alu_ce,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_operand1,
  output logic [31:0] alu_operand2,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        wb_illegal
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_LSL = 3'd5;
  localparam logic [2:0] ALU_LSR = 3'd6;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;

  logic [2:0]  dec_op;
  logic [31:0] dec_opnd1;
  logic [31:0] dec_opnd2;
  logic        dec_illegal;

  logic [2:0]  op_q;
  logic [31:0] opnd1_q;
  logic [31:0] opnd2_q;
  logic [4:0]  rd_q;
  logic        illegal_q;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};

  // Decode straight from the input bus so the accept edge can register the
  // final op and operands; EXEC then only replays the registered values.
  // Shift amounts are masked to 5 bits here so the ALU never sees a wider
  // shift count.
  always_comb begin
    dec_op      = ALU_ADD;
    dec_opnd1   = 32'd0;
    dec_opnd2   = 32'd0;
    dec_illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec_opnd1 = in_rs1_val;
        dec_opnd2 = in_rs2_val;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              dec_op      = ALU_ADD;
              dec_illegal = 1'b0;
            end else if (funct7 == 7'b0100000) begin
              dec_op      = ALU_SUB;
              dec_illegal = 1'b0;
            end
          end
          3'b001: begin
            if (funct7 == 7'b0000000) begin
              dec_op      = ALU_LSL;
              dec_opnd2   = {27'd0, in_rs2_val[4:0]};
              dec_illegal = 1'b0;
            end
          end
          3'b100: begin
            if (funct7 == 7'b0000000) begin
              dec_op      = ALU_XOR;
              dec_illegal = 1'b0;
            end
          end
          3'b101: begin
            if (funct7 == 7'b0000000) begin
              dec_op      = ALU_LSR;
              dec_opnd2   = {27'd0, in_rs2_val[4:0]};
              dec_illegal = 1'b0;
            end
          end
          3'b110: begin
            if (funct7 == 7'b0000000) begin
              dec_op      = ALU_OR;
              dec_illegal = 1'b0;
            end
          end
          3'b111: begin
            if (funct7 == 7'b0000000) begin
              dec_op      = ALU_AND;
              dec_illegal = 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
      OPC_OPIMM: begin
        if (ENABLE_OPIMM != 0) begin
          dec_opnd1 = in_rs1_val;
          dec_opnd2 = imm_i;
          case (funct3)
            3'b000: begin
              dec_op      = ALU_ADD;
              dec_illegal = 1'b0;
            end
            3'b100: begin
              dec_op      = ALU_XOR;
              dec_illegal = 1'b0;
            end
            3'b110: begin
              dec_op      = ALU_OR;
              dec_illegal = 1'b0;
            end
            3'b111: begin
              dec_op      = ALU_AND;
              dec_illegal = 1'b0;
            end
            3'b001: begin
              if (funct7 == 7'b0000000) begin
                dec_op      = ALU_LSL;
                dec_opnd2   = {27'd0, in_instr[24:20]};
                dec_illegal = 1'b0;
              end
            end
            3'b101: begin
              if (funct7 == 7'b0000000) begin
                dec_op      = ALU_LSR;
                dec_opnd2   = {27'd0, in_instr[24:20]};
                dec_illegal = 1'b0;
              end
            end
            default: begin
            end
          endcase
        end
      end
      OPC_LUI: begin
        if (ENABLE_LUI != 0) begin
          dec_op      = ALU_ADD;
          dec_opnd1   = 32'd0;
          dec_opnd2   = {in_instr[31:12], 12'd0};
          dec_illegal = 1'b0;
        end
      end
      default: begin
      end
    endcase
    if (dec_illegal) begin
      dec_op    = ALU_ADD;
      dec_opnd1 = 32'd0;
      dec_opnd2 = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Decoded instruction is captured only on accept, so it stays stable
  // through EXEC and for however long WB is back-pressured.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= ALU_ADD;
      opnd1_q   <= 32'd0;
      opnd2_q   <= 32'd0;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      op_q      <= dec_op;
      opnd1_q   <= dec_opnd1;
      opnd2_q   <= dec_opnd2;
      rd_q      <= in_instr[11:7];
      illegal_q <= dec_illegal;
    end
  end

  // Every output is forced low while rst is high, even in the cycle where
  // the state register still holds EXEC or WB, so a reset mid-operation
  // never leaks an alu_ce or wb_valid.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    alu_ce       = 1'b0;
    alu_op       = ALU_ADD;
    alu_operand1 = 32'd0;
    alu_operand2 = 32'd0;
    wb_valid     = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 32'd0;
    wb_we        = 1'b0;
    wb_illegal   = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            state_next = dec_illegal ? WB : EXEC;
          end
        end
        EXEC: begin
          alu_ce       = 1'b1;
          alu_op       = op_q;
          alu_operand1 = opnd1_q;
          alu_operand2 = opnd2_q;
          state_next   = WB;
        end
        WB: begin
          wb_valid   = 1'b1;
          wb_rd      = rd_q;
          wb_illegal = illegal_q;
          wb_data    = illegal_q ? 32'd0 : alu_result;
          wb_we      = (rd_q != 5'd0) && !illegal_q;
          if (wb_ready) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
//   Self-checking bench for alu_issue. A behavioural registered ALU feeds the
//   main instance; expected writeback values come from RV32I instruction
//   semantics computed directly in the bench. A second instance with LUI and
//   OP-IMM disabled checks the disabled-class behaviour.
module tb_alu_issue;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LSL = 3'd5;
  localparam logic [2:0] OP_LSR = 3'd6;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic        alu_ce;
  logic [2:0]  alu_op;
  logic [31:0] alu_operand1;
  logic [31:0] alu_operand2;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        wb_illegal;

  logic        in_valid2;
  logic        in_ready2;
  logic        alu_ce2;
  logic [2:0]  alu_op2;
  logic [31:0] alu_operand1_2;
  logic [31:0] alu_operand2_2;
  logic [31:0] alu_result2;
  logic        wb_valid2;
  logic        wb_ready2;
  logic [4:0]  wb_rd2;
  logic [31:0] wb_data2;
  logic        wb_we2;
  logic        wb_illegal2;

  int check_count = 0;
  int pass_count  = 0;

  alu_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .alu_ce(alu_ce), .alu_op(alu_op),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_we(wb_we), .wb_illegal(wb_illegal)
  );

  alu_issue #(.ENABLE_LUI(0), .ENABLE_OPIMM(0)) dut_min (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .alu_ce(alu_ce2), .alu_op(alu_op2),
    .alu_operand1(alu_operand1_2), .alu_operand2(alu_operand2_2),
    .alu_result(alu_result2),
    .wb_valid(wb_valid2), .wb_ready(wb_ready2), .wb_rd(wb_rd2),
    .wb_data(wb_data2), .wb_we(wb_we2), .wb_illegal(wb_illegal2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU: result only changes on a clock-enabled edge.
  initial alu_result = 32'd0;
  always @(posedge clk) begin
    if (alu_ce) begin
      case (alu_op)
        OP_ADD:  alu_result <= alu_operand1 + alu_operand2;
        OP_SUB:  alu_result <= alu_operand1 - alu_operand2;
        OP_AND:  alu_result <= alu_operand1 & alu_operand2;
        OP_OR:   alu_result <= alu_operand1 | alu_operand2;
        OP_XOR:  alu_result <= alu_operand1 ^ alu_operand2;
        OP_LSL:  alu_result <= alu_operand1 << alu_operand2[4:0];
        OP_LSR:  alu_result <= alu_operand1 >> alu_operand2[4:0];
        default: alu_result <= 32'hBAD0BAD0;
      endcase
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          hold;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic [2:0]  op;
    logic [31:0] op2;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [31:0] instr, logic [31:0] rs1, logic [31:0] rs2,
                              int hold, logic [31:0] data, logic ill,
                              logic [2:0] op, logic [31:0] op2);
    vec_t v;
    v.instr = instr;
    v.rs1   = rs1;
    v.rs2   = rs2;
    v.hold  = hold;
    v.data  = data;
    v.rd    = instr[11:7];
    v.we    = !ill && (instr[11:7] != 5'd0);
    v.ill   = ill;
    v.op    = op;
    v.op2   = op2;
    return v;
  endfunction

  function automatic logic [31:0] r_type(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(logic [11:0] imm, logic [2:0] f3, logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] u_type(logic [19:0] imm, logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  // Architectural result of an instruction, from RV32I semantics.
  function automatic void ref_model(input logic [31:0] instr, input logic [31:0] rs1,
                                    input logic [31:0] rs2, input bit en_lui,
                                    input bit en_opimm, output logic [31:0] data,
                                    output logic ill);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    f3   = instr[14:12];
    f7   = instr[31:25];
    imm  = {{20{instr[31]}}, instr[31:20]};
    data = 32'd0;
    ill  = 1'b1;
    case (instr[6:0])
      7'b0110011: begin
        if (f3 == 3'd0 && f7 == 7'h00) begin data = rs1 + rs2; ill = 1'b0; end
        if (f3 == 3'd0 && f7 == 7'h20) begin data = rs1 - rs2; ill = 1'b0; end
        if (f3 == 3'd1 && f7 == 7'h00) begin data = rs1 << rs2[4:0]; ill = 1'b0; end
        if (f3 == 3'd4 && f7 == 7'h00) begin data = rs1 ^ rs2; ill = 1'b0; end
        if (f3 == 3'd5 && f7 == 7'h00) begin data = rs1 >> rs2[4:0]; ill = 1'b0; end
        if (f3 == 3'd6 && f7 == 7'h00) begin data = rs1 | rs2; ill = 1'b0; end
        if (f3 == 3'd7 && f7 == 7'h00) begin data = rs1 & rs2; ill = 1'b0; end
      end
      7'b0010011: begin
        if (en_opimm) begin
          if (f3 == 3'd0) begin data = rs1 + imm; ill = 1'b0; end
          if (f3 == 3'd4) begin data = rs1 ^ imm; ill = 1'b0; end
          if (f3 == 3'd6) begin data = rs1 | imm; ill = 1'b0; end
          if (f3 == 3'd7) begin data = rs1 & imm; ill = 1'b0; end
          if (f3 == 3'd1 && f7 == 7'h00) begin data = rs1 << instr[24:20]; ill = 1'b0; end
          if (f3 == 3'd5 && f7 == 7'h00) begin data = rs1 >> instr[24:20]; ill = 1'b0; end
        end
      end
      7'b0110111: begin
        if (en_lui) begin data = {instr[31:12], 12'd0}; ill = 1'b0; end
      end
      default: begin
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one instruction to the main instance, reports what came out on
  // writeback, then back-pressures for 'hold' cycles and releases.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rs1,
                               input logic [31:0] rs2, input int hold,
                               output logic [31:0] g_data, output logic [4:0] g_rd,
                               output logic g_we, output logic g_ill,
                               output int g_lat, output int g_ce,
                               output logic [2:0] g_op, output logic [31:0] g_op2);
    g_data = 32'd0; g_rd = 5'd0; g_we = 1'b0; g_ill = 1'b0;
    g_lat = 0; g_ce = 0; g_op = 3'd7; g_op2 = 32'd0;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", {127'd0, in_ready}, 128'd1);
      return;
    end
    in_instr   = instr;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (alu_ce) begin
        g_ce++;
        g_op  = alu_op;
        g_op2 = alu_operand2;
      end
      if (wb_valid) begin
        g_lat  = c;
        g_data = wb_data;
        g_rd   = wb_rd;
        g_we   = wb_we;
        g_ill  = wb_illegal;
        break;
      end
      @(posedge clk); #1;
    end
    if (g_lat == 0) begin
      checkOutput("wb_valid_timeout", {127'd0, wb_valid}, 128'd1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_stable",
                  {87'd0, wb_valid, wb_data, wb_rd, wb_we, wb_illegal, in_ready, alu_ce},
                  {87'd0, 1'b1, g_data, g_rd, g_we, g_ill, 1'b0, 1'b0});
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    checkOutput("release_to_idle", {126'd0, in_ready, wb_valid}, {126'd0, 2'b10});
  endtask

  logic [31:0] g_data, exp_data;
  logic [4:0]  g_rd;
  logic        g_we, g_ill, exp_ill;
  int          g_lat, g_ce;
  logic [2:0]  g_op;
  logic [31:0] g_op2;
  logic [31:0] r_instr, r_rs1, r_rs2;
  logic        saw_wb;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(r_type(7'h00, 3'd0, 5'd3), 32'h7FFFFFFF, 32'h1, 5, 32'h80000000, 1'b0, OP_ADD, 32'h1);
    vecs[1]  = mk(i_type(12'hFFF, 3'd0, 5'd5), 32'h10, 32'h0, 0, 32'h0000000F, 1'b0, OP_ADD, 32'hFFFFFFFF);
    vecs[2]  = mk(r_type(7'h00, 3'd1, 5'd4), 32'h1, 32'h24, 0, 32'h10, 1'b0, OP_LSL, 32'h4);
    vecs[3]  = mk(i_type(12'h01F, 3'd5, 5'd6), 32'h80000000, 32'h0, 0, 32'h1, 1'b0, OP_LSR, 32'h1F);
    vecs[4]  = mk(r_type(7'h20, 3'd5, 5'd8), 32'h80000000, 32'h4, 5, 32'h0, 1'b1, OP_ADD, 32'h0);
    vecs[5]  = mk(u_type(20'hABCDE, 5'd7), 32'h12345678, 32'h9, 0, 32'hABCDE000, 1'b0, OP_ADD, 32'hABCDE000);
    vecs[6]  = mk(r_type(7'h20, 3'd0, 5'd9), 32'h5, 32'h7, 0, 32'hFFFFFFFE, 1'b0, OP_SUB, 32'h7);
    vecs[7]  = mk(r_type(7'h00, 3'd4, 5'd10), 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0FF00FF0, 1'b0, OP_XOR, 32'hFF00FF00);
    vecs[8]  = mk(i_type(12'h0F0, 3'd7, 5'd0), 32'h12345678, 32'h0, 1, 32'h70, 1'b0, OP_AND, 32'hF0);
    vecs[9]  = mk(i_type(12'h000, 3'd2, 5'd11), 32'h1, 32'h0, 0, 32'h0, 1'b1, OP_ADD, 32'h0);
    vecs[10] = mk(i_type(12'h41F, 3'd5, 5'd12), 32'h80000000, 32'h0, 0, 32'h0, 1'b1, OP_ADD, 32'h0);
    vecs[11] = mk(r_type(7'h00, 3'd6, 5'd13), 32'h00FF0000, 32'h0000FF00, 0, 32'h00FFFF00, 1'b0, OP_OR, 32'h0000FF00);
    vecs[12] = mk(i_type(12'h401, 3'd1, 5'd14), 32'h1, 32'h0, 0, 32'h0, 1'b1, OP_ADD, 32'h0);
    vecs[13] = mk({12'h0, 5'd1, 3'd2, 5'd15, 7'b0000011}, 32'h1, 32'h2, 0, 32'h0, 1'b1, OP_ADD, 32'h0);
    vecs[14] = mk(r_type(7'h00, 3'd5, 5'd16), 32'hF0000000, 32'hFFFFFFE4, 0, 32'h0F000000, 1'b0, OP_LSR, 32'h4);
    vecs[15] = mk(i_type(12'h800, 3'd6, 5'd17), 32'h1, 32'h0, 0, 32'hFFFFF801, 1'b0, OP_OR, 32'hFFFFF800);

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid2  = 1'b0;
    in_instr   = 32'd0;
    in_rs1_val = 32'd0;
    in_rs2_val = 32'd0;
    wb_ready   = 1'b0;
    wb_ready2  = 1'b1;
    alu_result2 = 32'hDEADBEEF;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_outputs_zero",
                {19'd0, in_ready, alu_ce, alu_op, alu_operand1, alu_operand2,
                 wb_valid, wb_rd, wb_data, wb_we, wb_illegal}, 128'd0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_reset", {127'd0, in_ready}, 128'd1);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].hold,
                    g_data, g_rd, g_we, g_ill, g_lat, g_ce, g_op, g_op2);
      checkOutput($sformatf("vec%0d_wb_data", i), {96'd0, g_data}, {96'd0, vecs[i].data});
      checkOutput($sformatf("vec%0d_wb_rd", i), {123'd0, g_rd}, {123'd0, vecs[i].rd});
      checkOutput($sformatf("vec%0d_wb_we", i), {127'd0, g_we}, {127'd0, vecs[i].we});
      checkOutput($sformatf("vec%0d_wb_illegal", i), {127'd0, g_ill}, {127'd0, vecs[i].ill});
      checkOutput($sformatf("vec%0d_latency", i), 128'(g_lat), vecs[i].ill ? 128'd1 : 128'd2);
      checkOutput($sformatf("vec%0d_ce_count", i), 128'(g_ce), vecs[i].ill ? 128'd0 : 128'd1);
      if (!vecs[i].ill) begin
        checkOutput($sformatf("vec%0d_alu_op", i), {125'd0, g_op}, {125'd0, vecs[i].op});
        checkOutput($sformatf("vec%0d_alu_operand2", i), {96'd0, g_op2}, {96'd0, vecs[i].op2});
      end
    end

    // Reset asserted while in EXEC drops the instruction
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    in_instr   = r_type(7'h00, 3'd0, 5'd3);
    in_rs1_val = 32'h11;
    in_rs2_val = 32'h22;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("exec_before_reset", {127'd0, alu_ce}, 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_in_exec_outputs_zero",
                {19'd0, in_ready, alu_ce, alu_op, alu_operand1, alu_operand2,
                 wb_valid, wb_rd, wb_data, wb_we, wb_illegal}, 128'd0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_mid_reset", {126'd0, in_ready, wb_valid}, {126'd0, 2'b10});
    saw_wb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      saw_wb = saw_wb | wb_valid | alu_ce;
    end
    checkOutput("no_wb_after_mid_reset", {127'd0, saw_wb}, 128'd0);

    // Disabled LUI / OP-IMM on the second instance
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20 && !in_ready2; i++) begin
        @(posedge clk); #1;
      end
      case (k)
        0: in_instr = u_type(20'hABCDE, 5'd7);
        1: in_instr = i_type(12'h005, 3'd0, 5'd9);
        default: in_instr = r_type(7'h00, 3'd0, 5'd4);
      endcase
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      if (k < 2) begin
        checkOutput($sformatf("disabled%0d_illegal_wb", k),
                    {89'd0, wb_valid2, wb_illegal2, wb_we2, alu_ce2, wb_rd2, wb_data2},
                    {89'd0, 1'b1, 1'b1, 1'b0, 1'b0, in_instr[11:7], 32'd0});
      end else begin
        checkOutput("min_add_ce", {126'd0, alu_ce2, wb_valid2}, {126'd0, 2'b10});
        @(posedge clk); #1;
        checkOutput("min_add_wb",
                    {90'd0, wb_valid2, wb_illegal2, wb_we2, wb_rd2, wb_data2},
                    {90'd0, 1'b1, 1'b0, 1'b1, 5'd4, 32'hDEADBEEF});
      end
      @(posedge clk); #1;
    end

    // Randomized instructions against the semantic model
    for (int n = 0; n < 150; n++) begin
      int kind;
      int f7sel;
      kind    = $urandom_range(0, 9);
      f7sel   = $urandom_range(0, 5);
      r_instr = $urandom();
      r_rs1   = $urandom();
      r_rs2   = $urandom();
      if (kind <= 4) begin
        r_instr[6:0] = 7'b0110011;
      end else if (kind <= 7) begin
        r_instr[6:0] = 7'b0010011;
      end else if (kind == 8) begin
        r_instr[6:0] = 7'b0110111;
      end
      if (kind <= 7 && f7sel <= 2) r_instr[31:25] = 7'h00;
      else if (kind <= 7 && f7sel <= 4) r_instr[31:25] = 7'h20;
      ref_model(r_instr, r_rs1, r_rs2, 1'b1, 1'b1, exp_data, exp_ill);
      applyStimulus(r_instr, r_rs1, r_rs2, int'($urandom_range(0, 2)),
                    g_data, g_rd, g_we, g_ill, g_lat, g_ce, g_op, g_op2);
      checkOutput("rand_wb_payload",
                  {88'd0, g_data, g_rd, g_we, g_ill},
                  {88'd0, exp_data, r_instr[11:7], !exp_ill && (r_instr[11:7] != 5'd0), exp_ill});
      checkOutput("rand_latency_ce", {64'd0, 32'(g_lat), 32'(g_ce)},
                  {64'd0, exp_ill ? 32'd1 : 32'd2, exp_ill ? 32'd0 : 32'd1});
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
